// File: rtl/timer_pkg.sv
// Shared types and helpers for the multi-channel interval timer.
package timer_pkg;

  typedef enum logic {ONE_SHOT = 1'b0, PERIODIC = 1'b1} timer_mode_e;
  typedef enum logic {T_IDLE, T_RUN} timer_state_e;

  // Prescaler counter width; a modulus of 1 still gets a 1-bit register.
  function automatic int presc_width(input int presc);
    return (presc > 1) ? $clog2(presc) : 1;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: period/mode latched on start, counts shared ticks, registered expiry pulse.
//   state  | meaning
//   T_IDLE | stopped, count held at 0, busy low
//   T_RUN  | counting ticks towards the latched period, busy high
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
  output logic             pulse,
  output logic             busy,
  output logic [WIDTH-1:0] count
);

  timer_state_e     state_q, state_d;
  timer_mode_e      mode_q, mode_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             pulse_q, pulse_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= T_IDLE;
      mode_q   <= ONE_SHOT;
      period_q <= '0;
      count_q  <= '0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      count_q  <= count_d;
      pulse_q  <= pulse_d;
    end
  end

  // Priority: stop > start > tick. period_q is never 0 while running, so P-1 cannot underflow.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    period_d = period_q;
    count_d  = count_q;
    pulse_d  = 1'b0;
    if (stop) begin
      state_d = T_IDLE;
      count_d = '0;
    end else if (start) begin
      count_d = '0;
      if (period != '0) begin
        state_d  = T_RUN;
        period_d = period;
        mode_d   = timer_mode_e'(mode);
      end else begin
        state_d = T_IDLE;
      end
    end else if (state_q == T_RUN && tick) begin
      if (count_q < period_q - WIDTH'(1)) begin
        count_d = count_q + WIDTH'(1);
      end else begin
        count_d = '0;
        pulse_d = 1'b1;
        if (mode_q == ONE_SHOT) state_d = T_IDLE;
      end
    end
  end

  always_comb begin
    busy  = (state_q == T_RUN);
    count = count_q;
    pulse = pulse_q;
  end

endmodule

// File: rtl/multi_timer.sv
// N-channel interval timer: one free-running shared prescaler feeding independent channels.
module multi_timer
  import timer_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int WIDTH = 25,
  parameter int PRESC = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [N_CH-1:0]            start,
  input  logic [N_CH-1:0]            stop,
  input  logic [N_CH-1:0]            mode,
  input  logic [N_CH-1:0][WIDTH-1:0] period,
  output logic [N_CH-1:0]            pulse,
  output logic [N_CH-1:0]            busy,
  output logic [N_CH-1:0][WIDTH-1:0] count
);

  localparam int PW = presc_width(PRESC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

  logic [PW-1:0] presc_cnt_q, presc_cnt_d;
  logic          tick;

  always_ff @(posedge clk) begin
    if (rst) presc_cnt_q <= '0;
    else     presc_cnt_q <= presc_cnt_d;
  end

  always_comb begin
    presc_cnt_d = presc_cnt_q;
    if (en) presc_cnt_d = (presc_cnt_q == PRESC_LAST) ? '0 : presc_cnt_q + PW'(1);
  end

  assign tick = en && (presc_cnt_q == PRESC_LAST);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .start (start[g]),
      .stop  (stop[g]),
      .mode  (mode[g]),
      .period(period[g]),
      .pulse (pulse[g]),
      .busy  (busy[g]),
      .count (count[g])
    );
  end

endmodule

// File: doc/multi_timer.md
# multi_timer

Parametrised multi-channel interval timer for the display/peripheral path. It replaces the fixed-modulus single pulse generator with N independent channels. Each channel has a runtime-loaded period, a periodic or one-shot mode, start/stop control, and pause via global enable. All channels share one prescaler, so CPU-side peripherals can schedule refresh, blink and timeout events from one block.

## Interface
- `N_CH`, 4: number of channels (1..16).
- `WIDTH`, 25: period/counter width in bits.
- `PRESC`, 1: shared prescaler modulus. One tick every `PRESC` enabled cycles; `PRESC` must be ≥ 1.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `en` in 1: global enable. Low pauses the prescaler and all channels.
- `start` in N_CH: per-channel start/restart request, level-sampled each cycle.
- `stop` in N_CH: per-channel stop request.
- `mode` in N_CH: 1 = periodic, 0 = one-shot. Latched on start.
- `period` in N_CH×WIDTH: per-channel period in ticks. Latched on start.
- `pulse` out N_CH: one-cycle registered expiry pulse.
- `busy` out N_CH: channel in RUN.
- `count` out N_CH×WIDTH: current channel count.

## Operation
- **Prescaler**
  - `presc_cnt` counts 0..PRESC-1 while `en`=1 and wraps after PRESC-1.
  - `tick` = `en` && (`presc_cnt` == PRESC-1), combinational. For PRESC=1, `tick` = `en`.
- **Channel states**
  - IDLE: `count`=0, `busy`=0.
  - RUN: `busy`=1.
- **IDLE → RUN** on `start`[i]=1 with `period`[i]≠0.
  - Latch `period` and `mode`; clear `count` to 0.
  - `start` with `period`=0 is ignored; the channel stays IDLE.
- **RUN, `start`[i]=1** (restart): re-latch `period`/`mode`, clear `count`, no pulse. `period`=0 here moves the channel to IDLE.
- **RUN on a tick**
  - If `count` < P-1: increment `count`.
  - Else: `count`←0 and `pulse`←1. Periodic stays in RUN; one-shot goes to IDLE.
- **RUN, `stop`[i]=1**: go to IDLE, `count`←0, no pulse.
- **Priority per channel**: `rst` > `stop` > `start` > tick.
  - Simultaneous `start`+`stop` → IDLE.
  - `start` in the same cycle as an expiry tick → restart wins; no pulse.
- **`en`=0**: prescaler, counts and states hold; `pulse` is 0.
  - `start`/`stop` are still accepted (state/latch update only).
- **Arithmetic**: comparison is unsigned WIDTH-bit. P = 2^WIDTH−1 is the maximum and must produce no overflow.
- Channels are fully independent except for the shared tick.

## Timing
- **Reset values**: `pulse`=0, `busy`=0, `count`=0, all channels IDLE, `presc_cnt`=0.
- `rst` asserted mid-run clears everything on the next edge. No pulse is emitted on that edge.
- **Start latency**: `start` sampled at edge t gives `busy`=1 and `count`=0 from t+1. The start cycle itself is not counted as a tick.
- **PRESC=1, `en`=1, period P**:
  - `pulse` is high for the cycle after edge t+P.
  - Periodic mode repeats every P cycles exactly.
  - P=1 gives a pulse every cycle.
- **PRESC>1**: the prescaler is free-running and not aligned to `start`. The first interval is between (P−1)·PRESC+1 and P·PRESC cycles; later intervals are exactly P·PRESC.
- **One-shot**: `busy` falls on the same edge that raises `pulse`.
- `pulse` is never high for more than one consecutive cycle unless P=1 in periodic mode.

## Structure
- **Package `timer_pkg`**
  - `typedef enum logic {ONE_SHOT=1'b0, PERIODIC=1'b1} timer_mode_e`
  - `typedef enum logic {T_IDLE, T_RUN} timer_state_e`
- **Sub-module `timer_channel`** (params WIDTH)
  - Ports: clk, rst, tick, start, stop, mode, period, pulse, busy, count.
  - Instantiated N_CH times via generate.
- **Top `multi_timer`**: holds the prescaler and the generate loop only. `presc_cnt` width is $clog2(PRESC) with a minimum of 1 bit.

## Test plan
- **Single periodic channel**: PRESC=1, ch0 periodic P=5, `start` pulse at cycle 10 → `pulse`[0] high at cycles 16, 21, 26…; `count` cycles 0..4.
- **One-shot**: P=3 started at cycle 0 → single `pulse` at cycle 4; `busy` low from cycle 4; no further pulses over 50 cycles.
- **Pause**: P=4 periodic, `en`=0 for 7 cycles mid-count at `count`=2 → `count` holds at 2, no pulse; resume → pulse 2 ticks after `en` rises.
- **Stop/start boundaries**
  - `stop` at `count`=P-1 on a tick → no pulse, IDLE.
  - `start`+`stop` same cycle → IDLE.
  - `start` with `period`=0 → `busy` stays 0.
- **Prescaler and channel independence**: PRESC=4, ch0 P=2 periodic, ch1 P=3 one-shot → ch0 pulses every 8 cycles; ch1 pulses once within 9..12 cycles of its start; channels do not interfere.
- **Reset and maximum period**: `rst` mid-run → all outputs 0 on the next edge. WIDTH=4, P=15 → pulse every 15 cycles with no wrap error.
